pipe_sel_mux: RTL and testbench
===============================

// Module: pipe_sel_mux
// PURPOSE
//   Parametrised N:1 datapath selector with a registered output stage and a
//   valid/ready skid buffer. It replaces the fixed 2:1/4:1 combinational
//   selectors on pipelined datapaths, such as the writeback and forwarding
//   operand paths. It also has a force-constant mode for link-register style
//   overrides and an out-of-range select error flag.
// PARAMETERS
//   WIDTH     32          data width, in bits
//   NSRC      4           number of sources, 2..16
//   SELW      $clog2(NSRC) width of sel; must be >= 1
//   FORCE_VAL {WIDTH{1'b1}} value emitted when force=1 (31 for 5-bit reg index)
//   CNTW      16          width of the accepted-transfer counter
// PORTS
//   clk        in   1           rising-edge clock
//   rst_n      in   1           synchronous reset, active low
//   in_valid   in   1           upstream presents a selection this cycle
//   in_ready   out  1           block can accept; registered, not comb of out_ready
//   sel        in   SELW        source index
//   force      in   1           1 = emit FORCE_VAL and ignore sel/data
//   in_data    in   NSRC*WIDTH  source k occupies bits [k*WIDTH +: WIDTH]
//   out_valid  out  1           out_data/out_err valid
//   out_ready  in   1           downstream accepts this cycle
//   out_data   out  WIDTH       selected word
//   out_err    out  1           sel >= NSRC at capture; out_data = 0 then
//   xfer_cnt   out  CNTW        count of accepted input transfers
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): out_valid=0, out_data=0, out_err=0,
//     xfer_cnt=0, skid empty, in_ready=1. Reset mid-transfer drops all held
//     words and has priority over any handshake in the same cycle.
//   - Accept: in_valid & in_ready at a posedge. Capture value:
//     force ? FORCE_VAL : (sel<NSRC ? in_data[sel] : 0). err = !force & sel>=NSRC.
//   - Emit: out_valid & out_ready at a posedge. The output changes only on
//     an emit or on a load into an empty main register.
//   - Storage: main register (drives outputs) plus one skid register.
//     States: EMPTY (main invalid), ONE (main valid), FULL (main + skid valid).
//     EMPTY: accept -> ONE, with main loaded. Latency is 1 cycle
//       (out_valid is high in the cycle after the accept).
//     ONE:
//       accept & emit  -> ONE, main reloaded with the new value.
//       accept & !emit -> FULL, value into skid.
//       emit & !accept -> EMPTY.
//     FULL: in_ready=0. Emit -> ONE, skid moves to main and skid clears.
//   - in_ready = !FULL, registered. No accept is possible in FULL.
//   - Ordering is strict FIFO. No word is duplicated or dropped.
//   - out_data and out_err are held stable while out_valid & !out_ready.
//   - xfer_cnt increments by 1 on each accept and wraps modulo 2^CNTW.
//   - Throughput is 1 word/cycle when out_ready is held high.
// TESTING
//   1. Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0,
//      in_ready=1, xfer_cnt=0, out_data=0.
//   2. Streaming: NSRC=4, WIDTH=32, sources 0xA0..0xA3, sel 0,1,2,3 on
//      consecutive cycles, out_ready=1 -> out_data 0xA0,0xA1,0xA2,0xA3 one
//      cycle after each accept; xfer_cnt=4.
//   3. Backpressure: out_ready=0, send sel=1 then sel=2 -> in_ready=0 after
//      the 2nd accept, out_data held at src1. Raise out_ready -> src1, then
//      src2; in_ready returns to 1.
//   4. Force and error: force=1 with sel=2 -> out_data=FORCE_VAL, out_err=0.
//      NSRC=3, sel=3, force=0 -> out_data=0, out_err=1.
//   5. Reset mid-operation: reach FULL, pulse rst_n=0 for 1 cycle -> both
//      words dropped, out_valid=0, in_ready=1 the next cycle.
//   6. Counter wrap: CNTW=4, 17 accepts -> xfer_cnt=1. Random valid/ready
//      for 1000 cycles -> scoreboard checks order and values match.

Source files
------------

// File: rtl/pipe_sel_mux.sv
// rtl/pipe_sel_mux.sv - N:1 registered selector with valid/ready skid buffer
// Main register drives the outputs; the skid register absorbs one word of backpressure.
module pipe_sel_mux #(
  parameter int                WIDTH     = 32,
  parameter int                NSRC      = 4,
  parameter int                SELW      = $clog2(NSRC),
  parameter logic [WIDTH-1:0]  FORCE_VAL = {WIDTH{1'b1}},
  parameter int                CNTW      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SELW-1:0]       sel,
  input  logic                  force_en,
  input  logic [NSRC*WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_err,
  output logic [CNTW-1:0]       xfer_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   sel_data, cap_data, skid_data;
  logic               hit, cap_err, skid_err;
  logic               accept, emit;
  logic               load_main, main_from_skid, load_skid;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  // Out-of-range selects (only possible when NSRC is not a power of two) never hit.
  always_comb begin
    sel_data = '0;
    hit      = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (sel == SELW'(k)) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
        hit      = 1'b1;
      end
    end
    cap_data = force_en ? FORCE_VAL : sel_data;
    cap_err  = !force_en && !hit;
  end

  always_comb begin
    state_nx       = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nx  = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (accept && emit) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_nx  = FULL;
          load_skid = 1'b1;
        end else if (emit) begin
          state_nx = EMPTY;
        end
      end
      FULL: begin
        if (emit) begin
          state_nx       = ONE;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  // Handshake flags are registered copies of the next state, so in_ready never depends on out_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= '0;
      out_err   <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
      xfer_cnt  <= '0;
    end else begin
      state     <= state_nx;
      out_valid <= (state_nx != EMPTY);
      in_ready  <= (state_nx != FULL);
      if (load_main) begin
        out_data <= main_from_skid ? skid_data : (cap_err ? '0 : cap_data);
        out_err  <= main_from_skid ? skid_err  : cap_err;
      end
      if (load_skid) begin
        skid_data <= cap_err ? '0 : cap_data;
        skid_err  <= cap_err;
      end
      if (accept) xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_sel_mux.sv
// tb/tb_pipe_sel_mux.sv - directed and scoreboard bench for pipe_sel_mux
// dut_a: NSRC=4, CNTW=16; dut_b: NSRC=3, CNTW=4, sharing the same stimulus.
module tb_pipe_sel_mux;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, force_en, out_ready;
  logic [1:0]   sel;
  logic [127:0] in_data;

  logic         a_in_ready, a_out_valid, a_out_err;
  logic [31:0]  a_out_data;
  logic [15:0]  a_xfer_cnt;
  logic         b_in_ready, b_out_valid, b_out_err;
  logic [31:0]  b_out_data;
  logic [3:0]   b_xfer_cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pipe_sel_mux #(.WIDTH(32), .NSRC(4), .CNTW(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .sel(sel), .force_en(force_en), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_err(a_out_err), .xfer_cnt(a_xfer_cnt)
  );

  pipe_sel_mux #(.WIDTH(32), .NSRC(3), .CNTW(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .sel(sel), .force_en(force_en), .in_data(in_data[95:0]),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_err(b_out_err), .xfer_cnt(b_xfer_cnt)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; sel = 2'd0; force_en = 1'b0; out_ready = 1'b0;
    in_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    cycle();
    cycle();
    n_total++; if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); else n_pass++;
    n_total++; if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", a_in_ready); else n_pass++;
    n_total++; if (a_xfer_cnt !== 16'd0) $display("FAIL reset_xfer_cnt got=%0d exp=0", a_xfer_cnt); else n_pass++;
    n_total++; if (a_out_data !== 32'd0) $display("FAIL reset_out_data got=%h exp=0", a_out_data); else n_pass++;
    rst_n = 1'b1; in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_streaming();
    logic [31:0] exp_data [4];
    exp_data = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      cycle();
      n_total++;
      if (a_out_valid !== 1'b1 || a_out_data !== exp_data[i])
        $display("FAIL stream_%0d got valid=%b data=%h exp valid=1 data=%h", i, a_out_valid, a_out_data, exp_data[i]);
      else n_pass++;
    end
    in_valid = 1'b0;
    cycle();
    n_total++; if (a_xfer_cnt !== 16'd4) $display("FAIL stream_cnt got=%0d exp=4", a_xfer_cnt); else n_pass++;
    n_total++; if (a_out_valid !== 1'b0) $display("FAIL stream_drain got valid=%b exp=0", a_out_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1;
    cycle();
    sel = 2'd2;
    cycle();
    in_valid = 1'b0;
    n_total++; if (a_in_ready !== 1'b0) $display("FAIL bp_full_ready got=%b exp=0", a_in_ready); else n_pass++;
    n_total++; if (a_out_data !== 32'hA1) $display("FAIL bp_first got=%h exp=a1", a_out_data); else n_pass++;
    cycle();
    n_total++;
    if (a_out_valid !== 1'b1 || a_out_data !== 32'hA1) $display("FAIL bp_hold got valid=%b data=%h exp valid=1 data=a1", a_out_valid, a_out_data);
    else n_pass++;
    out_ready = 1'b1;
    cycle();
    n_total++; if (a_out_data !== 32'hA2) $display("FAIL bp_second got=%h exp=a2", a_out_data); else n_pass++;
    n_total++; if (a_in_ready !== 1'b1) $display("FAIL bp_ready_back got=%b exp=1", a_in_ready); else n_pass++;
    cycle();
    n_total++; if (a_out_valid !== 1'b0) $display("FAIL bp_empty got valid=%b exp=0", a_out_valid); else n_pass++;
  endtask

  task automatic test_force_err();
    out_ready = 1'b1; in_valid = 1'b1; force_en = 1'b1; sel = 2'd2;
    cycle();
    n_total++;
    if (a_out_data !== 32'hFFFF_FFFF || a_out_err !== 1'b0) $display("FAIL force_a got data=%h err=%b exp data=ffffffff err=0", a_out_data, a_out_err);
    else n_pass++;
    force_en = 1'b0; sel = 2'd3;
    cycle();
    n_total++;
    if (b_out_data !== 32'd0 || b_out_err !== 1'b1) $display("FAIL err_b got data=%h err=%b exp data=0 err=1", b_out_data, b_out_err);
    else n_pass++;
    n_total++;
    if (a_out_data !== 32'hA3 || a_out_err !== 1'b0) $display("FAIL sel3_a got data=%h err=%b exp data=a3 err=0", a_out_data, a_out_err);
    else n_pass++;
    in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
    cycle();
    cycle();
    n_total++; if (a_in_ready !== 1'b0) $display("FAIL mid_full got in_ready=%b exp=0", a_in_ready); else n_pass++;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; in_valid = 1'b0;
    n_total++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_xfer_cnt !== 16'd0)
      $display("FAIL mid_reset got valid=%b ready=%b cnt=%0d exp valid=0 ready=1 cnt=0", a_out_valid, a_in_ready, a_xfer_cnt);
    else n_pass++;
    out_ready = 1'b1;
    cycle();
    n_total++; if (a_out_valid !== 1'b0) $display("FAIL mid_dropped got valid=%b exp=0", a_out_valid); else n_pass++;
  endtask

  task automatic test_counter_wrap();
    out_ready = 1'b1; in_valid = 1'b1; sel = 2'd1;
    for (int i = 0; i < 17; i++) cycle();
    in_valid = 1'b0;
    cycle();
    n_total++; if (b_xfer_cnt !== 4'd1) $display("FAIL wrap_b got=%0d exp=1", b_xfer_cnt); else n_pass++;
    n_total++; if (a_xfer_cnt !== 16'd17) $display("FAIL wrap_a got=%0d exp=17", a_xfer_cnt); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic [31:0] exp_word, held;
    logic        holding;
    holding = 1'b0;
    held    = '0;
    for (int c = 0; c < 1040; c++) begin
      if (holding) begin
        n_total++;
        if (a_out_data !== held) $display("FAIL rnd_hold cyc=%0d got=%h exp=%h", c, a_out_data, held);
        else n_pass++;
      end
      in_valid  = (c < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      out_ready = (c < 1000) ? 1'($urandom_range(0, 2) != 0) : 1'b1;
      sel       = 2'($urandom_range(0, 3));
      force_en  = ($urandom_range(0, 9) == 0);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      if (a_out_valid && out_ready) begin
        n_total++;
        if (q.size() == 0) $display("FAIL rnd_extra cyc=%0d got=%h exp=none", c, a_out_data);
        else begin
          exp_word = q.pop_front();
          if (a_out_data !== exp_word) $display("FAIL rnd_order cyc=%0d got=%h exp=%h", c, a_out_data, exp_word);
          else n_pass++;
        end
      end
      holding = a_out_valid && !out_ready;
      held    = a_out_data;
      if (in_valid && a_in_ready) q.push_back(force_en ? 32'hFFFF_FFFF : in_data[sel*32 +: 32]);
      cycle();
    end
    n_total++;
    if (q.size() != 0 || a_out_valid !== 1'b0) $display("FAIL rnd_drain got left=%0d valid=%b exp left=0 valid=0", q.size(), a_out_valid);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_force_err();
    test_reset_mid();
    test_counter_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
